// File: rtl/lc3_branch_pkg.sv
// lc3_branch_pkg: shared types, constants and helpers for the LC-3 branch resolve unit.
//   br_state_e : resolve FSM states (IDLE, EVAL, REQ, DONE)
//   OP_BR      : BR opcode in IR[15:12]
//   sext9      : PCoffset9 -> datapath-width sign extension
//   to_cnt_w   : ack wait counter width for a given timeout
package lc3_branch_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, REQ, DONE} br_state_e;
  localparam logic [3:0] OP_BR = 4'b0000;
  localparam int BR_WIDTH = 16;
  localparam int BR_OFFSET_W = 9;
  localparam int ACK_TIMEOUT_DEF = 15;
  function automatic logic [BR_WIDTH-1:0] sext9(input logic [BR_OFFSET_W-1:0] off);
    return {{(BR_WIDTH-BR_OFFSET_W){off[BR_OFFSET_W-1]}}, off};
  endfunction
  // A timeout of 0 disables the limit, but the counter still needs one bit.
  function automatic int to_cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction
  localparam int TO_CNT_W = to_cnt_w(ACK_TIMEOUT_DEF);
endpackage

// File: rtl/ben_eval.sv
// ben_eval: combinational BR condition check, shared with the control FSM.
//   opcode_i : IR[15:12]
//   cc_i     : IR[11:9] requested {n,z,p}
//   nzp_i    : current condition codes {N,Z,P}
//   ben_o    : branch enable
module ben_eval
  import lc3_branch_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [2:0] cc_i,
  input  logic [2:0] nzp_i,
  output logic       ben_o
);
  assign ben_o = (opcode_i == OP_BR) && |(cc_i & nzp_i);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves LC-3 BR instructions into BEN/Target and loads the PC via req/ack.
//   Clk, Reset(async, active low)
//   Start/IR/NZP/PC     : instruction snapshot request from the control FSM
//   Busy/BEN/Taken/Target, Done/Timeout : status and results
//   PC_Load_Req/PC_Load_Ack : handshake with the PC register
//   BRANCH_STATS_EN defined adds Taken_Count/NotTaken_Count saturating counters.
module branch_resolve_unit
  import lc3_branch_pkg::*;
#(
  parameter int WIDTH       = BR_WIDTH,
  parameter int OFFSET_W    = BR_OFFSET_W,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] IR,
  input  logic [2:0]       NZP,
  input  logic [WIDTH-1:0] PC,
  output logic             Busy,
  output logic             BEN,
  output logic             Taken,
  output logic [WIDTH-1:0] Target,
  output logic             PC_Load_Req,
  input  logic             PC_Load_Ack,
  output logic             Done,
  output logic             Timeout
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      Taken_Count,
  output logic [15:0]      NotTaken_Count
`endif
);
  localparam int CW = to_cnt_w(ACK_TIMEOUT);
  localparam logic [CW:0] TO = (CW+1)'(ACK_TIMEOUT);
  br_state_e state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [2:0] cc_q, cc_d, nzp_q, nzp_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [WIDTH-1:0] pc_q, pc_d, target_q, target_d;
  logic ben_q, ben_d, taken_q, taken_d, timeout_q, timeout_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW:0] wait_inc;
  logic ben_w, expired;
  ben_eval u_ben (.opcode_i(op_q), .cc_i(cc_q), .nzp_i(nzp_q), .ben_o(ben_w));
  assign wait_inc = {1'b0, wait_q} + (CW+1)'(1);
  // wait_inc counts the current REQ cycle, so the limit fires after exactly ACK_TIMEOUT cycles.
  assign expired = (ACK_TIMEOUT != 0) && (wait_inc == TO);
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cc_d      = cc_q;
    off_d     = off_q;
    pc_d      = pc_q;
    nzp_d     = nzp_q;
    ben_d     = ben_q;
    taken_d   = taken_q;
    target_d  = target_q;
    wait_d    = wait_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        state_d = EVAL;
        op_d    = IR[15:12];
        cc_d    = IR[11:9];
        off_d   = IR[OFFSET_W-1:0];
        pc_d    = PC;
        nzp_d   = NZP;
        taken_d = 1'b0;
      end
      EVAL: begin
        ben_d    = ben_w;
        target_d = pc_q + sext9(off_q);
        wait_d   = '0;
        state_d  = ben_w ? REQ : DONE;
      end
      REQ: begin
        wait_d = wait_inc[CW-1:0];
        if (PC_Load_Ack) begin
          taken_d = 1'b1;
          state_d = DONE;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cc_q      <= '0;
      off_q     <= '0;
      pc_q      <= '0;
      nzp_q     <= '0;
      ben_q     <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cc_q      <= cc_d;
      off_q     <= off_d;
      pc_q      <= pc_d;
      nzp_q     <= nzp_d;
      ben_q     <= ben_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign Busy        = state_q != IDLE;
  assign PC_Load_Req = state_q == REQ;
  assign Done        = state_q == DONE;
  assign BEN         = ben_q;
  assign Taken       = taken_q;
  assign Target      = target_q;
  assign Timeout     = timeout_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] tk_q, tk_d, nt_q, nt_d;
  always_comb begin
    tk_d = tk_q;
    nt_d = nt_q;
    if (state_q == DONE) begin
      tk_d = (taken_q && !(&tk_q)) ? tk_q + 16'd1 : tk_q;
      nt_d = (!taken_q && !(&nt_q)) ? nt_q + 16'd1 : nt_q;
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tk_q <= '0;
      nt_q <= '0;
    end else begin
      tk_q <= tk_d;
      nt_q <= nt_d;
    end
  end
  assign Taken_Count    = tk_q;
  assign NotTaken_Count = nt_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks of branch_resolve_unit against a reference model.
module tb_branch_resolve_unit;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0, ack0 = 1'b0;
  logic [15:0] ir = '0, pc = '0;
  logic [2:0] nzp = '0;
  logic busy0, ben0, taken0, req0, done0, to0, busy1, ben1, taken1, req1, done1, to1;
  logic [15:0] tgt0, tgt1;
  int total = 0, bad = 0, exp_tk = 0, exp_nt = 0;
`ifdef BRANCH_STATS_EN
  logic [15:0] tkc0, ntc0, tkc1, ntc1;
`endif
  always #5 clk = ~clk;
  branch_resolve_unit u_dut (
    .Clk(clk), .Reset(rst_n), .Start(start0), .IR(ir), .NZP(nzp), .PC(pc),
    .Busy(busy0), .BEN(ben0), .Taken(taken0), .Target(tgt0), .PC_Load_Req(req0),
    .PC_Load_Ack(ack0), .Done(done0), .Timeout(to0)
`ifdef BRANCH_STATS_EN
    , .Taken_Count(tkc0), .NotTaken_Count(ntc0)
`endif
  );
  branch_resolve_unit #(.ACK_TIMEOUT(3)) u_to (
    .Clk(clk), .Reset(rst_n), .Start(start1), .IR(ir), .NZP(nzp), .PC(pc),
    .Busy(busy1), .BEN(ben1), .Taken(taken1), .Target(tgt1), .PC_Load_Req(req1),
    .PC_Load_Ack(1'b0), .Done(done1), .Timeout(to1)
`ifdef BRANCH_STATS_EN
    , .Taken_Count(tkc1), .NotTaken_Count(ntc1)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Reference: BR is taken when any requested condition matches; target is PC plus signed offset.
  task automatic do_branch(input logic [15:0] i_ir, input logic [15:0] i_pc, input logic [2:0] i_nzp, input int dly);
    logic eb, eto;
    logic [15:0] et;
    int off, n;
    off = i_ir[8] ? int'(i_ir[8:0]) - 512 : int'(i_ir[8:0]);
    et  = 16'(int'(i_pc) + off);
    eb  = (i_ir[15:12] == 4'd0) && ((i_ir[11] && i_nzp[2]) || (i_ir[10] && i_nzp[1]) || (i_ir[9] && i_nzp[0]));
    eto = eb && dly >= 15;
    n   = (dly >= 15) ? 15 : dly + 1;
    ir = i_ir; pc = i_pc; nzp = i_nzp; start0 = 1'b1; ack0 = 1'($urandom);
    step();
    chk("busy_eval", busy0, 1); chk("taken_clear", taken0, 0);
    chk("done_eval", done0, 0); chk("req_eval", req0, 0);
    start0 = 1'($urandom); ir = 16'($urandom); pc = 16'($urandom); nzp = 3'($urandom); ack0 = 1'($urandom);
    step();
    chk("ben", ben0, eb); chk("target", tgt0, et);
    if (eb) begin
      ack0 = 1'b0;
      for (int i = 0; i < n; i++) begin
        chk("req", req0, 1); chk("done_in_req", done0, 0); chk("target_hold", tgt0, et);
        ack0 = (i >= dly); start0 = 1'($urandom);
        step();
      end
      ack0 = 1'($urandom);
    end
    chk("done", done0, 1); chk("req_in_done", req0, 0);
    chk("taken", taken0, eb && !eto); chk("timeout", to0, eto);
    if (eb && !eto) exp_tk++; else exp_nt++;
    step();
    start0 = 1'b0; ack0 = 1'b0;
    chk("idle_busy", busy0, 0); chk("done_pulse", done0, 0); chk("timeout_pulse", to0, 0);
    chk("taken_hold", taken0, eb && !eto); chk("ben_hold", ben0, eb); chk("target_idle", tgt0, et);
  endtask
  initial begin
    #12;
    chk("rst_busy", busy0, 0); chk("rst_ben", ben0, 0); chk("rst_taken", taken0, 0);
    chk("rst_target", tgt0, 0); chk("rst_req", req0, 0); chk("rst_done", done0, 0); chk("rst_timeout", to0, 0);
    step();
    rst_n = 1'b1;
    step();
    do_branch(16'h0E05, 16'h3001, 3'b001, 0);
    do_branch(16'h0803, 16'h3001, 3'b010, 0);
    do_branch(16'h03FF, 16'h0000, 3'b001, 4);
    do_branch(16'h1E05, 16'h3001, 3'b111, 0);
    do_branch(16'h0E05, 16'h3001, 3'b000, 0);
    do_branch(16'h0005, 16'h3001, 3'b111, 0);
    do_branch(16'h0F00, 16'hFF00, 3'b100, 20);
    ir = 16'h0E05; pc = 16'h1234; nzp = 3'b111; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("to_req", req1, 1); chk("to_early", to1, 0); chk("to_done_early", done1, 0);
      step();
    end
    chk("to_done", done1, 1); chk("to_pulse", to1, 1); chk("to_taken", taken1, 0);
    chk("to_req_drop", req1, 0); chk("to_ben", ben1, 1);
    step();
    chk("to_pulse_end", to1, 0); chk("to_idle", busy1, 0);
    ir = 16'h0E05; pc = 16'h4000; nzp = 3'b001; ack0 = 1'b0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    chk("pre_rst_req", req0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", req0, 0); chk("async_busy", busy0, 0);
    step();
    chk("rst_no_done", done0, 0); chk("rst_target2", tgt0, 0); chk("rst_ben2", ben0, 0);
    rst_n = 1'b1;
    do_branch(16'h0A10, 16'h2000, 3'b100, 1);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] r_ir;
      int r;
      r_ir = 16'($urandom);
      if ($urandom_range(3) != 0) r_ir[15:12] = 4'd0;
      r = int'($urandom_range(7));
      do_branch(r_ir, 16'($urandom), 3'($urandom), (r == 7) ? 20 : r);
    end
`ifdef BRANCH_STATS_EN
    chk("taken_count", tkc0, 16'(exp_tk));
    chk("nottaken_count", ntc0, 16'(exp_nt));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
